// File: rtl/cnt_down_timer_if.sv
// ---------------------------------------------------------------------------
// cnt_down_timer_if
// Groups the control and status signals of the loadable down-counting timer.
//
// Signals:
//   load     controller -> timer  load cnt_in as start and reload value
//   enab     controller -> timer  count enable
//   cnt_in   controller -> timer  start/reload value (WIDTH bits)
//   cnt_out  timer -> controller  current count (WIDTH bits)
//   busy     timer -> controller  high while counting
//   done     timer -> controller  one-cycle terminal-count pulse
//   expired  timer -> controller  level, high once a one-shot count ran out
//
// Modports:
//   master  the controller side (drives load/enab/cnt_in)
//   slave   the timer side (drives cnt_out/busy/done/expired)
// ---------------------------------------------------------------------------
interface cnt_down_timer_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic             enab;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             busy;
  logic             done;
  logic             expired;

  modport master (
    output load,
    output enab,
    output cnt_in,
    input  cnt_out,
    input  busy,
    input  done,
    input  expired
  );

  modport slave (
    input  load,
    input  enab,
    input  cnt_in,
    output cnt_out,
    output busy,
    output done,
    output expired
  );
endinterface

// File: rtl/cnt_down_timer.sv
// ---------------------------------------------------------------------------
// cnt_down_timer
// Loadable down-counting timer. A load sets the start value; each enabled
// cycle in RUN decrements by one. Reaching terminal count pulses done and
// either parks the block in EXPIRED (one-shot) or reloads the start value
// and keeps counting (auto-reload).
//
// Build option:
//   CNT_AUTO_RELOAD_EN  when defined, terminal count reloads the stored
//                       start value and stays in RUN; expired is then 0.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   cnt_down_timer_if.slave (load, enab, cnt_in in;
//         cnt_out, busy, done, expired out)
// ---------------------------------------------------------------------------
module cnt_down_timer #(
  parameter int WIDTH = 5
) (
  input logic              clk,
  input logic              rst,
  cnt_down_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

`ifdef CNT_AUTO_RELOAD_EN
  // The start value is kept so terminal count can restart the period.
  logic [WIDTH-1:0] rld_q, rld_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rld_q <= '0;
    end else begin
      rld_q <= rld_d;
    end
  end
`endif

  // State, count and done pulse registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. A load wins over counting in any state, so a load on
  // the terminal edge restarts the count and no done is produced. done is
  // only ever set by a terminal edge, which makes it a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef CNT_AUTO_RELOAD_EN
    rld_d   = rld_q;
`endif

    if (bus.load) begin
      cnt_d   = bus.cnt_in;
`ifdef CNT_AUTO_RELOAD_EN
      rld_d   = bus.cnt_in;
`endif
      state_d = (bus.cnt_in != ZERO) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.enab) begin
            if (cnt_q == ONE) begin
              done_d = 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
              cnt_d   = rld_q;
              state_d = RUN;
`else
              cnt_d   = ZERO;
              state_d = EXPIRED;
`endif
            end else if (cnt_q > ONE) begin
              // Decrement only from 2 upward so the count can never wrap.
              cnt_d = cnt_q - ONE;
            end
          end
        end
        EXPIRED: begin
          cnt_d = ZERO;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == RUN);
`ifdef CNT_AUTO_RELOAD_EN
  assign bus.expired = 1'b0;
`else
  assign bus.expired = (state_q == EXPIRED);
`endif

endmodule

// File: tb/tb_cnt_down_timer.sv
// ---------------------------------------------------------------------------
// tb_cnt_down_timer
// Self-checking bench for cnt_down_timer: directed scenarios followed by
// randomized load/enable traffic, all compared against a behavioural model
// of the timer kept as plain integers.
// ---------------------------------------------------------------------------
module tb_cnt_down_timer;

  localparam int WIDTH = 5;
`ifdef CNT_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining count, remembered start value, and flags.
  int mCnt;
  int mRld;
  bit mRunning;
  bit mExpired;
  bit mDone;

  cnt_down_timer_if #(.WIDTH(WIDTH)) bus ();

  cnt_down_timer #(.WIDTH(WIDTH)) dut (
    .clk (clock),
    .rst (reset),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCnt     = 0;
    mRld     = 0;
    mRunning = 1'b0;
    mExpired = 1'b0;
    mDone    = 1'b0;
  endtask

  // One clock edge of timer behaviour, described from the user's view.
  task automatic modelStep(input bit ld, input bit en, input int cin);
    mDone = 1'b0;
    if (ld) begin
      mCnt     = cin;
      mRld     = cin;
      mRunning = (cin != 0);
      mExpired = 1'b0;
    end else if (mRunning && en) begin
      if (mCnt == 1) begin
        mDone = 1'b1;
        if (AUTO) begin
          mCnt = mRld;
        end else begin
          mCnt     = 0;
          mRunning = 1'b0;
          mExpired = 1'b1;
        end
      end else begin
        mCnt = mCnt - 1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".cnt_out"}, int'(bus.cnt_out), mCnt);
    checkOutput({tag, ".busy"},    int'(bus.busy),    int'(mRunning));
    checkOutput({tag, ".done"},    int'(bus.done),    int'(mDone));
    checkOutput({tag, ".expired"}, int'(bus.expired), int'(mExpired));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check 1 unit later.
  task automatic applyStimulus(input bit ld, input bit en, input int cin, input string tag);
    @(negedge clock);
    bus.load   = ld;
    bus.enab   = en;
    bus.cnt_in = WIDTH'(cin);
    @(posedge clock);
    modelStep(ld, en, cin);
    #1;
    compareAll(tag);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    modelReset();
    compareAll("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  int cyclesToDone;
  bit sawDone;

  initial begin
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.enab   = 1'b0;
    bus.cnt_in = '0;
    modelReset();

    doReset();

    // Async reset mid-count, then confirm the block stays idle without a load.
    applyStimulus(1'b1, 1'b0, 9, "asyncLoad");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 0, "asyncRun");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll("asyncRst");
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 0, "postRst");

    // One-shot from 3 with continuous enable, then extra enables.
    applyStimulus(1'b1, 1'b1, 3, "oneShotLoad");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 0, "oneShot");

    // Enable gating: 1,0,0,1,1 from 5.
    applyStimulus(1'b1, 1'b0, 5, "gateLoad");
    applyStimulus(1'b0, 1'b1, 0, "gate");
    applyStimulus(1'b0, 1'b0, 0, "gate");
    applyStimulus(1'b0, 1'b0, 0, "gate");
    applyStimulus(1'b0, 1'b1, 0, "gate");
    applyStimulus(1'b0, 1'b1, 0, "gate");

    // Load while running beats the enable; then a zero load goes idle.
    applyStimulus(1'b1, 1'b0, 3, "prioLoad");
    applyStimulus(1'b0, 1'b1, 0, "prioRun");
    applyStimulus(1'b1, 1'b1, 7, "prioReload");
    applyStimulus(1'b1, 1'b1, 1, "prioOne");
    applyStimulus(1'b1, 1'b1, 0, "prioZero");
    applyStimulus(1'b0, 1'b1, 0, "prioIdle");

    // Full scale: done must appear exactly 31 cycles after the load edge.
    applyStimulus(1'b1, 1'b0, 31, "fullLoad");
    cyclesToDone = 0;
    sawDone      = 1'b0;
    for (int i = 1; i <= 40 && !sawDone; i++) begin
      applyStimulus(1'b0, 1'b1, 0, "full");
      if (bus.done) begin
        sawDone      = 1'b1;
        cyclesToDone = i;
      end
    end
    checkOutput("fullScaleLatency", cyclesToDone, 31);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 0, "fullAfter");

    // Period 2 run; reload behaviour shows up only in the auto-reload build.
    applyStimulus(1'b1, 1'b1, 2, "periodLoad");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 0, "period");

    // Randomized traffic with small values favoured to hit terminal count often.
    for (int i = 0; i < 600; i++) begin
      bit ld;
      bit en;
      int cin;
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      cin = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4))
                                        : int'($urandom_range(0, 31));
      if ($urandom_range(0, 149) == 0) begin
        doReset();
      end else begin
        applyStimulus(ld, en, cin, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_down_timer.md
# cnt_down_timer

Loadable down-counting timer: the decrementing counterpart of the team's loadable up-counter. Software or a controlling FSM loads a start value; the block counts down one step per enabled cycle. At terminal count it flags expiry, and optionally reloads itself for periodic ticks. Used as a timeout and interval source alongside the up-counter in the same clock domain.

## Interface
- WIDTH, default 5: counter and load-value width in bits.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; all state and outputs clear immediately on assertion.
- load  input  1  load cnt_in as start and reload value; highest priority after rst.
- enab  input  1  count enable; one decrement per cycle while running.
- cnt_in  input  WIDTH  start/reload value, sampled only when load=1.
- cnt_out  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in the cycle after a terminal-count edge.
- expired  output  1  level, high in EXPIRED until the next load or rst.

## Operation
- States: IDLE, RUN, EXPIRED. Internal reload register `rld` is WIDTH bits.
- Reset values:
  - state = IDLE
  - cnt_out = 0, rld = 0
  - busy = 0, done = 0, expired = 0
- Priority on every edge: rst > load > enab > hold.
- load=1, any state:
  - cnt_out <= cnt_in, rld <= cnt_in, done <= 0.
  - Next state is RUN if cnt_in != 0, else IDLE.
  - A load in RUN restarts the count and suppresses any terminal event on that edge.
- IDLE: cnt_out holds; enab ignored.
- RUN, enab=1, cnt_out > 1: cnt_out <= cnt_out - 1.
- RUN, enab=1, cnt_out == 1 is the terminal-count edge; done <= 1. Without the macro, cnt_out <= 0 and next state is EXPIRED.
- RUN, enab=0: cnt_out holds; done <= 0.
- EXPIRED: cnt_out stays 0; enab ignored; expired=1.
- busy = (state==RUN) and expired = (state==EXPIRED), both decoded from registered state.
- Arithmetic: a decrement is issued only when cnt_out >= 2 or at terminal count, so the counter never wraps below 0. The full-scale value 2^WIDTH-1 loads and counts correctly.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Load latency 1: cnt_out = cnt_in in the cycle after the load edge, and busy rises in that same cycle.
- A load value N with continuous enab reaches terminal count N cycles after the load edge.
- done is high for exactly one cycle, coincident with the first cycle of cnt_out==0, or of the reloaded value when auto-reload is enabled.
- rst asserted mid-count clears outputs asynchronously. After rst deasserts, the block stays in IDLE until a load.

## Configuration
- CNT_AUTO_RELOAD_EN defined:
  - The terminal-count edge loads cnt_out <= rld instead of 0, pulses done, and keeps the state in RUN.
  - EXPIRED is unreachable and expired is constant 0.
  - Period is rld enabled cycles.
- CNT_AUTO_RELOAD_EN undefined: one-shot behaviour as described in Operation.

## Test plan
- Async reset: load 9, run 3 cycles, assert rst between clock edges -> cnt_out=0, busy=0, done=0, expired=0 before the next edge; the block stays idle after release.
- One-shot: load 3, enab held 1 -> cnt_out sequence 3,2,1,0; done=1 only in the cnt_out=0 cycle; expired=1 and busy=0 thereafter; further enab leaves cnt_out at 0.
- Enable gating: load 5, enab pattern 1,0,0,1,1 -> cnt_out sequence 5,4,4,4,3,2; no done.
- Load priority: while running at cnt_out=2, apply load=1 with cnt_in=7 and enab=1 -> cnt_out=7 next cycle, done stays 0, busy stays 1. Separately, load 0 -> cnt_out=0, IDLE, busy=0, no done.
- Full scale: load 31 (WIDTH=5), enab continuous -> done exactly 31 cycles after the load edge; no wrap to 31 afterwards.
- CNT_AUTO_RELOAD_EN: load 2, enab continuous -> cnt_out sequence 2,1,2,1,...; done pulses every 2nd cycle, aligned with cnt_out=2 after the first period; expired stays 0.
